// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between burst instruction fetch and LSB loads/stores.
// LSB wins arbitration; reads are pipelined one byte per cycle, and stores stall on a full I/O buffer.
module mem_arbiter #(
   parameter int FETCH_WORDS = 8,
   parameter bit IO_STALL_EN = 1'b1
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        fetch_req_in,
   input  logic [31:0] fetch_addr_in,
   output logic        fetch_word_valid_out,
   output logic [31:0] fetch_word_out,
   output logic        fetch_done_out,
   input  logic        lsb_req_in,
   input  logic        lsb_we_in,
   input  logic [1:0]  lsb_size_in,
   input  logic [31:0] lsb_addr_in,
   input  logic [31:0] lsb_wdata_in,
   output logic [31:0] lsb_rdata_out,
   output logic        lsb_done_out,
   input  logic        rollback_in
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_FETCH} state_t;
   localparam logic [5:0] FETCH_LAST = 6'(4 * FETCH_WORDS - 1);

   state_t      state_q, state_d;
   logic [31:0] base_q, base_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  byte_q, byte_d;
   logic [3:0]  word_q, word_d;
   logic [5:0]  iss_q, iss_d;
   logic        rd_vld_q, rd_vld_d;
   logic [23:0] asm_q, asm_d;
   logic [31:0] fword_q, fword_d;
   logic        fvld_q, fvld_d, fdone_q, fdone_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ldone_q, ldone_d;

   logic        reading, capture, cap_last, abort, io_stall, st_go, st_last;
   logic [1:0]  n_last;
   logic [5:0]  cap_off, last_off;
   logic [31:0] st_addr;

   always_comb begin
      case (size_q)
         2'd0:    n_last = 2'd0;
         2'd1:    n_last = 2'd1;
         default: n_last = 2'd3;
      endcase
   end

   // rd_vld_q: mem_din currently carries the byte at the capture offset
   assign reading  = (state_q == S_LOAD) || (state_q == S_FETCH);
   assign cap_off  = {word_q, byte_q};
   assign last_off = (state_q == S_FETCH) ? FETCH_LAST : {4'd0, n_last};
   assign capture  = rdy_in && reading && rd_vld_q;
   assign cap_last = capture && (cap_off == last_off);
   assign abort    = rdy_in && reading && rollback_in;
   assign st_addr  = base_q + {30'd0, byte_q};
   assign io_stall = IO_STALL_EN && io_buffer_full && (st_addr[17:16] == 2'b11);
   assign st_go    = rdy_in && (state_q == S_STORE) && !io_stall;
   assign st_last  = st_go && (byte_q == n_last);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (rdy_in && !rollback_in) begin
               if (lsb_req_in)        state_d = lsb_we_in ? S_STORE : S_LOAD;
               else if (fetch_req_in) state_d = S_FETCH;
            end
         end
         S_LOAD, S_FETCH: if (abort || cap_last) state_d = S_IDLE;
         S_STORE:         if (st_last) state_d = S_IDLE;
         default:         state_d = S_IDLE;
      endcase
   end

   // While frozen the capture offset is re-addressed so the lost byte is re-read on resume
   always_comb begin
      mem_a    = 32'd0;
      mem_wr   = 1'b0;
      mem_dout = 8'd0;
      case (state_q)
         S_LOAD, S_FETCH: mem_a = base_q + {26'd0, (rdy_in ? iss_q : cap_off)};
         S_STORE: begin
            mem_a    = st_addr;
            mem_wr   = st_go;
            mem_dout = 8'(wdata_q >> {byte_q, 3'b000});
         end
         default: ;
      endcase
   end

   always_comb begin
      base_d   = base_q;
      size_d   = size_q;
      wdata_d  = wdata_q;
      byte_d   = byte_q;
      word_d   = word_q;
      iss_d    = iss_q;
      rd_vld_d = rd_vld_q;
      asm_d    = asm_q;
      fword_d  = fword_q;
      rdata_d  = rdata_q;
      fvld_d   = 1'b0;
      fdone_d  = 1'b0;
      ldone_d  = 1'b0;
      if (state_q == S_IDLE && state_d != S_IDLE) begin
         base_d           = lsb_req_in ? lsb_addr_in : fetch_addr_in;
         size_d           = lsb_size_in;
         wdata_d          = lsb_wdata_in;
         {word_d, byte_d} = 6'd0;
         iss_d            = 6'd0;
         rd_vld_d         = 1'b0;
      end
      if (reading) begin
         rd_vld_d = 1'b1;
         if (!rdy_in)                 iss_d = (cap_off == last_off) ? cap_off : cap_off + 6'd1;
         else if (iss_q != last_off)  iss_d = iss_q + 6'd1;
      end
      if (capture) begin
         {word_d, byte_d} = cap_off + 6'd1;
         case (byte_q)
            2'd0:    asm_d[7:0]   = mem_din;
            2'd1:    asm_d[15:8]  = mem_din;
            2'd2:    asm_d[23:16] = mem_din;
            default: ;
         endcase
         if (state_q == S_FETCH && byte_q == 2'd3 && !abort) begin
            fword_d = {mem_din, asm_q};
            fvld_d  = 1'b1;
            fdone_d = cap_last;
         end
         if (state_q == S_LOAD && cap_last && !abort) begin
            ldone_d = 1'b1;
            case (size_q)
               2'd0:    rdata_d = {24'd0, mem_din};
               2'd1:    rdata_d = {16'd0, mem_din, asm_q[7:0]};
               default: rdata_d = {mem_din, asm_q};
            endcase
         end
      end
      if (st_go)   byte_d  = byte_q + 2'd1;
      if (st_last) ldone_d = 1'b1;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         base_q   <= 32'd0;
         size_q   <= 2'd0;
         wdata_q  <= 32'd0;
         byte_q   <= 2'd0;
         word_q   <= 4'd0;
         iss_q    <= 6'd0;
         rd_vld_q <= 1'b0;
         asm_q    <= 24'd0;
         fword_q  <= 32'd0;
         fvld_q   <= 1'b0;
         fdone_q  <= 1'b0;
         rdata_q  <= 32'd0;
         ldone_q  <= 1'b0;
      end else begin
         base_q   <= base_d;
         size_q   <= size_d;
         wdata_q  <= wdata_d;
         byte_q   <= byte_d;
         word_q   <= word_d;
         iss_q    <= iss_d;
         rd_vld_q <= rd_vld_d;
         asm_q    <= asm_d;
         fword_q  <= fword_d;
         fvld_q   <= fvld_d;
         fdone_q  <= fdone_d;
         rdata_q  <= rdata_d;
         ldone_q  <= ldone_d;
      end
   end

   assign fetch_word_valid_out = fvld_q;
   assign fetch_word_out       = fword_q;
   assign fetch_done_out       = fdone_q;
   assign lsb_rdata_out        = rdata_q;
   assign lsb_done_out         = ldone_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model (RAM[a] = a[7:0], plus 11 22 33 44 at 0x2000).
module tb_mem_arbiter;
   logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
   logic [7:0]  mem_din = 8'd0;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full = 1'b0;
   logic        fetch_req_in = 1'b0;
   logic [31:0] fetch_addr_in = 32'd0;
   logic        fetch_word_valid_out, fetch_done_out;
   logic [31:0] fetch_word_out;
   logic        lsb_req_in = 1'b0, lsb_we_in = 1'b0;
   logic [1:0]  lsb_size_in = 2'd0;
   logic [31:0] lsb_addr_in = 32'd0, lsb_wdata_in = 32'd0;
   logic [31:0] lsb_rdata_out;
   logic        lsb_done_out;
   logic        rollback_in = 1'b0;
   int          n_chk = 0, n_pass = 0;

   mem_arbiter #(.FETCH_WORDS(8), .IO_STALL_EN(1'b1)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full),
      .fetch_req_in(fetch_req_in), .fetch_addr_in(fetch_addr_in),
      .fetch_word_valid_out(fetch_word_valid_out), .fetch_word_out(fetch_word_out),
      .fetch_done_out(fetch_done_out),
      .lsb_req_in(lsb_req_in), .lsb_we_in(lsb_we_in), .lsb_size_in(lsb_size_in),
      .lsb_addr_in(lsb_addr_in), .lsb_wdata_in(lsb_wdata_in),
      .lsb_rdata_out(lsb_rdata_out), .lsb_done_out(lsb_done_out),
      .rollback_in(rollback_in)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      case (a)
         32'h0000_2000: return 8'h11;
         32'h0000_2001: return 8'h22;
         32'h0000_2002: return 8'h33;
         32'h0000_2003: return 8'h44;
         default:       return a[7:0];
      endcase
   endfunction

   always @(posedge clk_in) mem_din <= ram_rd(mem_a);

   // Word k of a burst from 0x1000 holds bytes 4k..4k+3
   function automatic logic [31:0] fw(input int k);
      logic [7:0] b;
      b = 8'(4 * k);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   task automatic test_reset();
      @(posedge clk_in); @(negedge clk_in);
      n_chk++; if (mem_a !== 32'd0) $display("FAIL rst_mem_a got %h exp 0", mem_a); else n_pass++;
      n_chk++; if (mem_wr !== 1'b0) $display("FAIL rst_mem_wr got %b exp 0", mem_wr); else n_pass++;
      n_chk++; if (mem_dout !== 8'd0) $display("FAIL rst_mem_dout got %h exp 0", mem_dout); else n_pass++;
      n_chk++; if (fetch_word_valid_out !== 1'b0) $display("FAIL rst_fvld got %b exp 0", fetch_word_valid_out); else n_pass++;
      n_chk++; if (fetch_word_out !== 32'd0) $display("FAIL rst_fword got %h exp 0", fetch_word_out); else n_pass++;
      n_chk++; if (fetch_done_out !== 1'b0) $display("FAIL rst_fdone got %b exp 0", fetch_done_out); else n_pass++;
      n_chk++; if (lsb_rdata_out !== 32'd0) $display("FAIL rst_rdata got %h exp 0", lsb_rdata_out); else n_pass++;
      n_chk++; if (lsb_done_out !== 1'b0) $display("FAIL rst_ldone got %b exp 0", lsb_done_out); else n_pass++;
      @(posedge clk_in); #1 rst_in = 1'b0;
   endtask

   task automatic test_fetch();
      logic vexp;
      @(posedge clk_in); #1;
      fetch_req_in = 1'b1; fetch_addr_in = 32'h1000;
      for (int t = 0; t <= 34; t++) begin
         @(posedge clk_in); #1;
         if (t == 33) fetch_req_in = 1'b0;
         @(negedge clk_in);
         vexp = (t >= 5) && ((t - 5) % 4 == 0) && (t <= 33);
         if (t < 32) begin
            n_chk++; if (mem_a !== 32'h1000 + 32'(t)) $display("FAIL fetch_addr t=%0d got %h exp %h", t, mem_a, 32'h1000 + 32'(t)); else n_pass++;
         end
         n_chk++; if (fetch_word_valid_out !== vexp) $display("FAIL fetch_vld t=%0d got %b exp %b", t, fetch_word_valid_out, vexp); else n_pass++;
         if (vexp) begin
            n_chk++; if (fetch_word_out !== fw((t - 5) / 4)) $display("FAIL fetch_word t=%0d got %h exp %h", t, fetch_word_out, fw((t - 5) / 4)); else n_pass++;
         end
         n_chk++; if (fetch_done_out !== (t == 33)) $display("FAIL fetch_done t=%0d got %b exp %b", t, fetch_done_out, (t == 33)); else n_pass++;
      end
      n_chk++; if (mem_a !== 32'd0) $display("FAIL fetch_idle_addr got %h exp 0", mem_a); else n_pass++;
   endtask

   task automatic test_priority();
      @(posedge clk_in); #1;
      lsb_req_in = 1'b1; lsb_we_in = 1'b0; lsb_size_in = 2'd2; lsb_addr_in = 32'h2000;
      fetch_req_in = 1'b1; fetch_addr_in = 32'h1000;
      for (int t = 0; t <= 7; t++) begin
         @(posedge clk_in); #1;
         if (t == 5) lsb_req_in = 1'b0;
         if (t == 6) begin rollback_in = 1'b1; fetch_req_in = 1'b0; end
         if (t == 7) rollback_in = 1'b0;
         @(negedge clk_in);
         if (t < 4) begin
            n_chk++; if (mem_a !== 32'h2000 + 32'(t)) $display("FAIL prio_load_addr t=%0d got %h exp %h", t, mem_a, 32'h2000 + 32'(t)); else n_pass++;
         end
         n_chk++; if (lsb_done_out !== (t == 5)) $display("FAIL prio_done t=%0d got %b exp %b", t, lsb_done_out, (t == 5)); else n_pass++;
         if (t == 5) begin
            n_chk++; if (lsb_rdata_out !== 32'h44332211) $display("FAIL prio_rdata got %h exp 44332211", lsb_rdata_out); else n_pass++;
            n_chk++; if (mem_a !== 32'd0) $display("FAIL prio_done_idle got %h exp 0", mem_a); else n_pass++;
         end
         if (t == 6) begin
            n_chk++; if (mem_a !== 32'h1000) $display("FAIL prio_fetch_start got %h exp 00001000", mem_a); else n_pass++;
         end
         if (t == 7) begin
            n_chk++; if (mem_a !== 32'd0) $display("FAIL prio_abort_idle got %h exp 0", mem_a); else n_pass++;
         end
         n_chk++; if (fetch_word_valid_out !== 1'b0) $display("FAIL prio_fvld t=%0d got %b exp 0", t, fetch_word_valid_out); else n_pass++;
      end
   endtask

   task automatic test_store_io();
      @(posedge clk_in); #1;
      lsb_req_in = 1'b1; lsb_we_in = 1'b1; lsb_size_in = 2'd1; lsb_addr_in = 32'h30000;
      lsb_wdata_in = 32'hDEADBEEF; io_buffer_full = 1'b1;
      for (int t = 0; t <= 6; t++) begin
         @(posedge clk_in); #1;
         if (t == 3) io_buffer_full = 1'b0;
         if (t == 5) lsb_req_in = 1'b0;
         @(negedge clk_in);
         n_chk++; if (mem_wr !== (t == 3 || t == 4)) $display("FAIL sto_wr t=%0d got %b exp %b", t, mem_wr, (t == 3 || t == 4)); else n_pass++;
         if (t == 3) begin
            n_chk++; if (mem_a !== 32'h30000 || mem_dout !== 8'hEF) $display("FAIL sto_byte0 got %h/%h exp 00030000/ef", mem_a, mem_dout); else n_pass++;
         end
         if (t == 4) begin
            n_chk++; if (mem_a !== 32'h30001 || mem_dout !== 8'hBE) $display("FAIL sto_byte1 got %h/%h exp 00030001/be", mem_a, mem_dout); else n_pass++;
         end
         n_chk++; if (lsb_done_out !== (t == 5)) $display("FAIL sto_done t=%0d got %b exp %b", t, lsb_done_out, (t == 5)); else n_pass++;
      end
   endtask

   task automatic test_rollback_fetch();
      logic vexp;
      @(posedge clk_in); #1;
      fetch_req_in = 1'b1; fetch_addr_in = 32'h1000;
      for (int t = 0; t <= 18; t++) begin
         @(posedge clk_in); #1;
         if (t == 14) begin rollback_in = 1'b1; fetch_req_in = 1'b0; end
         if (t == 15) begin rollback_in = 1'b0; fetch_req_in = 1'b1; fetch_addr_in = 32'h2000; end
         if (t == 17) begin rollback_in = 1'b1; fetch_req_in = 1'b0; end
         if (t == 18) rollback_in = 1'b0;
         @(negedge clk_in);
         vexp = (t == 5) || (t == 9) || (t == 13);
         n_chk++; if (fetch_word_valid_out !== vexp) $display("FAIL rb_fvld t=%0d got %b exp %b", t, fetch_word_valid_out, vexp); else n_pass++;
         n_chk++; if (fetch_done_out !== 1'b0) $display("FAIL rb_fdone t=%0d got %b exp 0", t, fetch_done_out); else n_pass++;
         if (t == 13) begin
            n_chk++; if (fetch_word_out !== fw(2)) $display("FAIL rb_word2 got %h exp %h", fetch_word_out, fw(2)); else n_pass++;
         end
         if (t == 15 || t == 18) begin
            n_chk++; if (mem_a !== 32'd0) $display("FAIL rb_idle t=%0d got %h exp 0", t, mem_a); else n_pass++;
         end
         if (t == 16 || t == 17) begin
            n_chk++; if (mem_a !== 32'h2000 + 32'(t - 16)) $display("FAIL rb_new_addr t=%0d got %h exp %h", t, mem_a, 32'h2000 + 32'(t - 16)); else n_pass++;
         end
      end
   endtask

   task automatic test_rollback_store();
      logic [7:0] bexp;
      @(posedge clk_in); #1;
      lsb_req_in = 1'b1; lsb_we_in = 1'b1; lsb_size_in = 2'd2; lsb_addr_in = 32'h4000;
      lsb_wdata_in = 32'hA1B2C3D4;
      for (int t = 0; t <= 5; t++) begin
         @(posedge clk_in); #1;
         rollback_in = (t == 1);
         if (t == 4) lsb_req_in = 1'b0;
         @(negedge clk_in);
         if (t < 4) begin
            bexp = 8'(32'hA1B2C3D4 >> (8 * t));
            n_chk++; if (mem_wr !== 1'b1 || mem_a !== 32'h4000 + 32'(t) || mem_dout !== bexp)
               $display("FAIL rbs_write t=%0d got %b/%h/%h exp 1/%h/%h", t, mem_wr, mem_a, mem_dout, 32'h4000 + 32'(t), bexp);
            else n_pass++;
         end
         n_chk++; if (lsb_done_out !== (t == 4)) $display("FAIL rbs_done t=%0d got %b exp %b", t, lsb_done_out, (t == 4)); else n_pass++;
      end
      n_chk++; if (mem_a !== 32'd0 || mem_wr !== 1'b0) $display("FAIL rbs_idle got %h/%b exp 0/0", mem_a, mem_wr); else n_pass++;
   endtask

   task automatic test_rdy_stall();
      logic vexp;
      int   kexp;
      @(posedge clk_in); #1;
      fetch_req_in = 1'b1; fetch_addr_in = 32'h1000;
      for (int t = 0; t <= 38; t++) begin
         @(posedge clk_in); #1;
         if (t == 14) rdy_in = 1'b0;
         if (t == 18) rdy_in = 1'b1;
         if (t == 37) fetch_req_in = 1'b0;
         @(negedge clk_in);
         vexp = 1'b0; kexp = 0;
         for (int k = 0; k < 8; k++)
            if (4 * k + 5 + ((4 * k + 5 > 14) ? 4 : 0) == t) begin vexp = 1'b1; kexp = k; end
         if (t < 14) begin
            n_chk++; if (mem_a !== 32'h1000 + 32'(t)) $display("FAIL stall_addr t=%0d got %h exp %h", t, mem_a, 32'h1000 + 32'(t)); else n_pass++;
         end else if (t < 18) begin
            n_chk++; if (mem_wr !== 1'b0) $display("FAIL stall_wr t=%0d got %b exp 0", t, mem_wr); else n_pass++;
         end else if (t < 36) begin
            n_chk++; if (mem_a !== 32'h1000 + 32'(t - 4)) $display("FAIL stall_addr t=%0d got %h exp %h", t, mem_a, 32'h1000 + 32'(t - 4)); else n_pass++;
         end
         n_chk++; if (fetch_word_valid_out !== vexp) $display("FAIL stall_fvld t=%0d got %b exp %b", t, fetch_word_valid_out, vexp); else n_pass++;
         if (vexp) begin
            n_chk++; if (fetch_word_out !== fw(kexp)) $display("FAIL stall_word t=%0d got %h exp %h", t, fetch_word_out, fw(kexp)); else n_pass++;
         end
         n_chk++; if (fetch_done_out !== (t == 37)) $display("FAIL stall_done t=%0d got %b exp %b", t, fetch_done_out, (t == 37)); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_load();
      @(posedge clk_in); #1;
      lsb_req_in = 1'b1; lsb_we_in = 1'b0; lsb_size_in = 2'd2; lsb_addr_in = 32'h2000;
      for (int t = 0; t <= 2; t++) begin
         @(posedge clk_in); #1;
         @(negedge clk_in);
         n_chk++; if (mem_a !== 32'h2000 + 32'(t)) $display("FAIL mrst_addr t=%0d got %h exp %h", t, mem_a, 32'h2000 + 32'(t)); else n_pass++;
      end
      #1 rst_in = 1'b1;
      #1;
      n_chk++; if (mem_a !== 32'd0 || mem_wr !== 1'b0 || mem_dout !== 8'd0)
         $display("FAIL mrst_port got %h/%b/%h exp 0/0/0", mem_a, mem_wr, mem_dout);
      else n_pass++;
      n_chk++; if (lsb_rdata_out !== 32'd0 || lsb_done_out !== 1'b0)
         $display("FAIL mrst_lsb got %h/%b exp 0/0", lsb_rdata_out, lsb_done_out);
      else n_pass++;
      n_chk++; if (fetch_word_out !== 32'd0 || fetch_word_valid_out !== 1'b0 || fetch_done_out !== 1'b0)
         $display("FAIL mrst_fetch got %h/%b/%b exp 0/0/0", fetch_word_out, fetch_word_valid_out, fetch_done_out);
      else n_pass++;
      lsb_req_in = 1'b0;
      @(posedge clk_in); #1 rst_in = 1'b0;
      @(negedge clk_in);
      n_chk++; if (mem_a !== 32'd0 || lsb_done_out !== 1'b0) $display("FAIL mrst_after got %h/%b exp 0/0", mem_a, lsb_done_out); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_store_io();
      test_rollback_fetch();
      test_rollback_store();
      test_rdy_stall();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-wide RAM port between the instruction fetcher (multi-word burst reads for icache fills) and the load/store buffer (single loads and stores of 1, 2 or 4 bytes). It sits between Fetcher/LSB and the top-level `mem_*` pins. It serialises byte accesses, assembles little-endian words, stalls on a full I/O buffer and aborts speculative reads on ROB rollback.

## Interface
- `FETCH_WORDS`, 8: words per fetch burst (1..16).
- `IO_STALL_EN`, 1: honour `io_buffer_full` on stores to the I/O region.

- `clk_in` in 1: clock; all state changes on the rising edge.
- `rst_in` in 1: reset, asynchronous and active-high.
- `rdy_in` in 1: global enable; low freezes the block.
- `mem_din` in 8: RAM read data for the address driven the previous cycle.
- `mem_dout` out 8: RAM write data.
- `mem_a` out 32: RAM byte address.
- `mem_wr` out 1: 1 = write, 0 = read.
- `io_buffer_full` in 1: UART buffer full.
- `fetch_req_in` in 1: burst request, level, held until `fetch_done_out` or rollback.
- `fetch_addr_in` in 32: burst start address.
- `fetch_word_valid_out` out 1: one-cycle pulse per assembled word.
- `fetch_word_out` out 32: assembled instruction word.
- `fetch_done_out` out 1: pulse with the last word.
- `lsb_req_in` in 1: access request, level, held until `lsb_done_out`.
- `lsb_we_in` in 1: 1 = store.
- `lsb_size_in` in 2: 0 = byte, 1 = half, 2 = word.
- `lsb_addr_in` in 32: access address.
- `lsb_wdata_in` in 32: store data, low bytes used.
- `lsb_rdata_out` out 32: load data, zero-extended.
- `lsb_done_out` out 1: one-cycle completion pulse.
- `rollback_in` in 1: ROB flush.

## Operation
- **States:**
  - IDLE → LOAD, STORE or FETCH on a sampled request.
  - Each busy state returns to IDLE after its last byte.
- **Arbitration in IDLE:**
  - `lsb_req_in` beats `fetch_req_in`.
  - No grant in a cycle where `rollback_in` is high.
  - The request inputs are latched at grant.
- **Access length:** n = 1, 2 or 4 bytes from `lsb_size_in`; a fetch is 4·FETCH_WORDS bytes.
- **Byte addressing:**
  - Byte i is at base+i, with 32-bit wrap.
  - Byte i lands in bits [8i+7:8i], little-endian.
- **Counters:** a 2-bit byte counter and a 4-bit word counter.
- **FETCH:**
  - Address issue continues across word boundaries with no bubbles.
  - Each word is pulsed on `fetch_word_valid_out` once its 4th byte is captured.
- **STORE:**
  - Drives `mem_wr`=1 with byte i on `mem_dout`.
  - The I/O region is `addr[17:16]`==2'b11.
  - For I/O addresses with `io_buffer_full`=1 and `IO_STALL_EN`=1: `mem_wr`=0 and the counter holds.
- **Rollback:**
  - In FETCH or LOAD: go to IDLE at the next edge, with no further valid or done pulses.
  - In STORE: ignored, because committed stores always complete.
- **rdy_in low:**
  - State and counters hold and `mem_wr`=0.
  - The issue index rewinds to the capture index, so the in-flight byte is re-read on resume.
- **Outside STORE:** `mem_a`=0 in IDLE and `mem_wr`=0.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE, immediately (asynchronous), including mid-access.
- **Grant latency:** a request seen in IDLE at cycle T-1 puts the first address on `mem_a` at cycle T.
- **Read:** byte i is addressed at T+i, appears on `mem_din` at T+i+1 and is registered at the end of that cycle.
- **LOAD:** `lsb_rdata_out` and `lsb_done_out` are valid at T+n+1.
- **FETCH:** word k is valid at T+4k+5; `fetch_done_out` is valid at T+4·FETCH_WORDS+1.
- **STORE:** bytes are written at T..T+n-1 plus stall cycles; `lsb_done_out` follows at the next cycle.
- **Done pulses:**
  - Each lasts exactly one cycle, and the state is IDLE in that cycle.
  - The earliest next grant is the cycle after the done cycle, so the requester must drop its request in the done cycle.
- **Rollback and completion in the same cycle:** rollback wins for FETCH/LOAD, and the done is suppressed.

## Test plan
- Fetch burst from 0x1000, RAM[a]=a[7:0]:
  - `mem_a` steps 0x1000..0x101F at T..T+31.
  - Word 0 = 0x03020100 at T+5 and word 7 = 0x1F1E1D1C at T+33, with `fetch_done_out`.
- Same-cycle `fetch_req_in` and `lsb_req_in` (load word at 0x2000, RAM bytes 11 22 33 44):
  - `lsb_rdata_out`=0x44332211 at T+5.
  - Fetch addresses start the cycle after the done cycle.
- Store half 0xBEEF to 0x30000 with `io_buffer_full` high for 3 cycles:
  - `mem_wr`=0 for 3 cycles, then 0xEF→0x30000 and 0xBE→0x30001.
  - `lsb_done_out` one cycle later.
- Rollback during fetch word 3:
  - No further valid pulses and no done.
  - IDLE next cycle; a new fetch at 0x2000 issues its first address 2 cycles after the rollback.
- Rollback during a word store: all 4 bytes are written and `lsb_done_out` pulses.
- `rst_in` asserted mid-load and `rdy_in` low for 4 cycles mid-fetch:
  - Reset: outputs are 0 before the next edge.
  - Stall: word values are unchanged versus the no-stall run, shifted by 4 cycles.
